// File: rtl/fetch_unit_if.sv
// Bundles the signals between the fetch stage, instruction memory and decode.
// The master modport is the fetch stage. The slave modport is its environment:
// memory plus decode/execute.
interface fetch_unit_if;
  // instruction memory request/ack bus
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // decode-side output slot and back-pressure
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  // redirects from execute (branch) and decode (jump)
  logic        redirect_branch;
  logic [31:0] branch_pc;
  logic [15:0] branch_offset;
  logic        redirect_jump;
  logic [31:0] jump_pc;
  logic [25:0] jump_targ;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, stall,
    input  redirect_branch, branch_pc, branch_offset,
    input  redirect_jump, jump_pc, jump_targ
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, stall,
    output redirect_branch, branch_pc, branch_offset,
    output redirect_jump, jump_pc, jump_targ
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. It owns the PC and fetches over a req/ack memory bus.
// It presents one registered instruction per cycle to decode, and it parks one
// instruction in a skid register when decode stalls. Redirects flush the
// output slot and the skid. A redirect that arrives while an access is still
// outstanding lets that access finish in DROP, and its data is discarded.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, FULL, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] ipc_reg, ipc_next;
  logic        valid_reg, valid_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc_reg, skid_pc_next;

  logic        slot_free;
  logic        redirect;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [3:0]  jump_region;
  logic [31:0] redirect_target;

  // Redirect target arithmetic. A branch wins over a jump because it is older.
  assign jump_region     = 4'((bus.jump_pc + 32'd4) >> 28);
  assign jump_target     = {jump_region, bus.jump_targ, 2'b00};
  assign branch_target   = bus.branch_pc + 32'd4 +
                           {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign redirect        = bus.redirect_branch | bus.redirect_jump;
  assign redirect_target = bus.redirect_branch ? branch_target : jump_target;
  assign slot_free       = !valid_reg || !bus.stall;

  // Moore request: asserted whenever an access is outstanding (REQ or DROP)
  assign bus.imem_req    = (state_reg == REQ) || (state_reg == DROP);
  assign bus.imem_addr   = addr_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = ipc_reg;
  assign bus.instr_valid = valid_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and datapath next values; redirect overrides everything else
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    addr_next       = addr_reg;
    instr_next      = instr_reg;
    ipc_next        = ipc_reg;
    valid_next      = valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;

    // When decode consumes the slot and nothing new loads, the slot drains to a NOP
    if (!bus.stall) begin
      valid_next = 1'b0;
      instr_next = 32'h0;
    end

    if (redirect) begin
      pc_next         = redirect_target;
      valid_next      = 1'b0;
      instr_next      = 32'h0;
      skid_instr_next = 32'h0;
      skid_pc_next    = 32'h0;
      case (state_reg)
        REQ, DROP: begin
          if (bus.imem_ack) begin
            // The outstanding access ends this cycle, so refetch at once
            addr_next  = redirect_target;
            state_next = REQ;
          end else begin
            state_next = DROP;
          end
        end
        default: begin
          addr_next  = redirect_target;
          state_next = REQ;
        end
      endcase
    end else begin
      case (state_reg)
        IDLE: begin
          addr_next  = pc_reg;
          state_next = REQ;
        end
        REQ: begin
          if (bus.imem_ack) begin
            pc_next = pc_reg + 32'd4;
            if (slot_free) begin
              instr_next = bus.imem_rdata;
              ipc_next   = addr_reg;
              valid_next = 1'b1;
              addr_next  = pc_reg + 32'd4;
            end else begin
              skid_instr_next = bus.imem_rdata;
              skid_pc_next    = addr_reg;
              state_next      = FULL;
            end
          end
        end
        FULL: begin
          if (!bus.stall) begin
            instr_next      = skid_instr_reg;
            ipc_next        = skid_pc_reg;
            valid_next      = 1'b1;
            skid_instr_next = 32'h0;
            skid_pc_next    = 32'h0;
            addr_next       = pc_reg;
            state_next      = REQ;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            addr_next  = pc_reg;
            state_next = REQ;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath registers: PC, memory address, output slot and skid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg         <= RESET_PC;
      addr_reg       <= RESET_PC;
      instr_reg      <= 32'h0;
      ipc_reg        <= 32'h0;
      valid_reg      <= 1'b0;
      skid_instr_reg <= 32'h0;
      skid_pc_reg    <= 32'h0;
    end else begin
      pc_reg         <= pc_next;
      addr_reg       <= addr_next;
      instr_reg      <= instr_next;
      ipc_reg        <= ipc_next;
      valid_reg      <= valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
    end
  end

endmodule
